// File: rtl/dds_pkg.sv
// dds_pkg: shared types and width helpers for the DDS receive-side blocks.
//   ACC_W_DEF    default phase-accumulator / frequency-word width
//   meas_state_t period-measurement FSM states
//   div_state_t  sequential-divider FSM states
//   dividend_w() dividend width for (PERIODS << ACC_W) style quotients
package dds_pkg;

  localparam int unsigned ACC_W_DEF = 24;

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } meas_state_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_RUN  = 2'd1,
    D_DONE = 2'd2
  } div_state_t;

  // Low-part dividend width: ACC_W plus the bits needed to scale by PERIODS.
  function automatic int unsigned dividend_w(input int unsigned acc_w,
                                             input int unsigned periods);
    return acc_w + $clog2(periods);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock.
// Computes {dividend_hi_i, dividend_lo_i} / divisor_i, where dividend_hi_i
// must be smaller than divisor_i so the quotient fits in LO_W bits; this lets
// an (LO_W+1)-bit or wider numerator finish in LO_W iterations.
//   clk, rst       clock, synchronous active-high reset
//   start_i        load operands (sampled in D_IDLE only)
//   abort_i        drop any running division without a done pulse
//   dividend_hi_i  upper numerator part, initial partial remainder
//   dividend_lo_i  lower numerator part, shifted in MSB first
//   divisor_i      divisor, captured on start
//   quotient_o     low Q_W bits of the quotient, valid while done_o is high
//   busy_o         high in D_RUN and D_DONE
//   done_o         one-cycle pulse in D_DONE
module seq_divider
  import dds_pkg::*;
#(
  parameter int unsigned LO_W  = 28,
  parameter int unsigned DVS_W = 32,
  parameter int unsigned Q_W   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [DVS_W-1:0] dividend_hi_i,
  input  logic [LO_W-1:0]  dividend_lo_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic [Q_W-1:0]   quotient_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned IT_W = $clog2(LO_W);

  div_state_t        state_q, state_d;
  logic [DVS_W-1:0]  rem_q, rem_d;
  logic [DVS_W-1:0]  dvs_q, dvs_d;
  logic [LO_W-1:0]   dq_q, dq_d;      // dividend bits out at the top, quotient bits in at the bottom
  logic [IT_W-1:0]   it_q, it_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DVS_W:0]    shift_c;
  logic [DVS_W+1:0]  diff_c;
  logic              qbit_c;

  // Trial subtraction; the top bit of diff_c is the borrow.
  always_comb begin
    shift_c = {rem_q, dq_q[LO_W-1]};
    diff_c  = {1'b0, shift_c} - {2'b00, dvs_q};
    qbit_c  = ~diff_c[DVS_W+1];
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dq_d    = dq_q;
    it_d    = it_q;
    case (state_q)
      D_IDLE: begin
        if (start_i) begin
          state_d = D_RUN;
          rem_d   = dividend_hi_i;
          dvs_d   = divisor_i;
          dq_d    = dividend_lo_i;
          it_d    = IT_W'(LO_W - 1);
        end
      end
      D_RUN: begin
        // Restored remainder is always below the divisor, so DVS_W bits suffice.
        rem_d = qbit_c ? DVS_W'(diff_c) : DVS_W'(shift_c);
        dq_d  = {dq_q[LO_W-2:0], qbit_c};
        it_d  = it_q - IT_W'(1);
        if (it_q == '0) state_d = D_DONE;
      end
      D_DONE:  state_d = D_IDLE;
      default: state_d = D_IDLE;
    endcase
    if (abort_i) state_d = D_IDLE;
    busy_d = (state_d == D_RUN) || (state_d == D_DONE);
    done_d = (state_d == D_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= D_IDLE;
      rem_q   <= '0;
      dvs_q   <= '0;
      dq_q    <= '0;
      it_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dq_q    <= dq_d;
      it_q    <= it_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quotient_o = dq_q[Q_W-1:0];
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: rtl/fword_meter.sv
// fword_meter: measures the period of sig_in averaged over PERIODS rising
// edges and recovers the equivalent DDS frequency word
//   fword = (PERIODS << ACC_W) / total_cycles.
// Build option: FWORD_ROUND_EN adds total/2 to the numerator (round to
// nearest) at the cost of one extra pre-add cycle of latency.
//   clk        system clock
//   rst        synchronous reset, active-high
//   sig_in     measured signal, asynchronous to clk
//   fword      last recovered frequency word (0 while no signal)
//   fword_vld  one-cycle pulse when fword updates
//   no_signal  high until the first result and after an input timeout
//   busy       high while the divider runs
module fword_meter
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W       = ACC_W_DEF,
  parameter int unsigned PERIODS     = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [ACC_W-1:0] fword,
  output logic             fword_vld,
  output logic             no_signal,
  output logic             busy
);

  localparam int unsigned DVD_W = dividend_w(ACC_W, PERIODS);
  localparam int unsigned EC_W  = $clog2(PERIODS);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

  meas_state_t       state_q, state_d;
  logic [2:0]        sync_q;
  logic              edge_c, win_c, tmo_c;
  logic [CNT_W-1:0]  cyc_q, cyc_d;     // cycles since the window start edge
  logic [EC_W-1:0]   ecnt_q, ecnt_d;
  logic [TO_W-1:0]   idle_q, idle_d;   // cycles since the most recent edge
  logic              div_start;
  logic [CNT_W-1:0]  div_hi, div_dvs;
  logic [DVD_W-1:0]  div_lo;
  logic [ACC_W-1:0]  div_quot;
  logic              div_busy, div_done;
  logic [ACC_W-1:0]  fword_q, fword_d;
  logic              vld_q, vld_d;
  logic              nosig_q, nosig_d;

  // Two-flop synchronizer plus a third flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], sig_in};
  end
  assign edge_c = sync_q[1] & ~sync_q[2];

  // Measurement FSM: back-to-back windows of PERIODS edges; edge beats timeout.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    ecnt_d  = ecnt_q;
    idle_d  = idle_q;
    win_c   = 1'b0;
    tmo_c   = 1'b0;
    case (state_q)
      WAIT_EDGE: begin
        idle_d = '0;
        if (edge_c) begin
          state_d = MEASURE;
          cyc_d   = CNT_W'(1);
          ecnt_d  = '0;
          idle_d  = TO_W'(1);
        end
      end
      MEASURE: begin
        cyc_d  = cyc_q + CNT_W'(1);
        idle_d = idle_q + TO_W'(1);
        if (edge_c) begin
          idle_d = TO_W'(1);
          ecnt_d = ecnt_q + EC_W'(1);
          if (ecnt_q == EC_W'(PERIODS - 1)) begin
            // Closing edge doubles as the next window's start edge.
            win_c  = 1'b1;
            cyc_d  = CNT_W'(1);
            ecnt_d = '0;
          end
        end else if ((idle_q >= TO_W'(TIMEOUT_CYC - 1)) || (cyc_q == '1)) begin
          tmo_c   = 1'b1;
          state_d = WAIT_EDGE;
        end
      end
      default: state_d = WAIT_EDGE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_EDGE;
      cyc_q   <= '0;
      ecnt_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ecnt_q  <= ecnt_d;
      idle_q  <= idle_d;
    end
  end

  // PERIODS is a power of two, so PERIODS << ACC_W is 1 << DVD_W: the high
  // dividend part is 1 (plus the rounding carry) and always below total.
`ifdef FWORD_ROUND_EN
  localparam int unsigned NUM_W = DVD_W + CNT_W;
  logic              start_q, start_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [NUM_W-1:0]  num_c;

  always_comb begin
    start_d = win_c;
    total_d = win_c ? cyc_q : total_q;
    num_c   = (NUM_W'(1) << DVD_W) + NUM_W'(total_q >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      total_q <= '0;
    end else begin
      start_q <= start_d;
      total_q <= total_d;
    end
  end

  assign div_start = start_q;
  assign div_hi    = num_c[NUM_W-1:DVD_W];
  assign div_lo    = num_c[DVD_W-1:0];
  assign div_dvs   = total_q;
`else
  assign div_start = win_c;
  assign div_hi    = CNT_W'(1);
  assign div_lo    = '0;
  assign div_dvs   = cyc_q;
`endif

  seq_divider #(
    .LO_W  (DVD_W),
    .DVS_W (CNT_W),
    .Q_W   (ACC_W)
  ) u_div (
    .clk           (clk),
    .rst           (rst),
    .start_i       (div_start),
    .abort_i       (tmo_c),
    .dividend_hi_i (div_hi),
    .dividend_lo_i (div_lo),
    .divisor_i     (div_dvs),
    .quotient_o    (div_quot),
    .busy_o        (div_busy),
    .done_o        (div_done)
  );

  // Result registers; a timeout clears the word and flags loss of signal.
  always_comb begin
    fword_d = fword_q;
    vld_d   = 1'b0;
    nosig_d = nosig_q;
    if (tmo_c) begin
      fword_d = '0;
      nosig_d = 1'b1;
    end else if (div_done) begin
      fword_d = div_quot;
      vld_d   = 1'b1;
      nosig_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fword_q <= '0;
      vld_q   <= 1'b0;
      nosig_q <= 1'b1;
    end else begin
      fword_q <= fword_d;
      vld_q   <= vld_d;
      nosig_q <= nosig_d;
    end
  end

  assign fword     = fword_q;
  assign fword_vld = vld_q;
  assign no_signal = nosig_q;
  assign busy      = div_busy;

endmodule
